// File: rtl/bcd_to_binary_seq.sv
// rtl/bcd_to_binary_seq.sv - sequential packed-BCD to binary converter (reverse double-dabble)
//
// Purpose:
//   Converts a packed BCD operand into its binary value by shifting {bcd,bin}
//   right one bit per cycle. After each shift, 3 is subtracted from every BCD
//   digit that is 8 or more. One result takes BIN_W shift cycles plus a DONE
//   cycle, and the next start can be accepted in the IDLE cycle after that.
//
// Ports:
//   clk_50MHz  in   1         system clock, rising edge
//   reset      in   1         asynchronous, active-low
//   start      in   1         conversion request, sampled only while idle
//   bcd_in     in   4*DIGITS  packed BCD operand, digit 0 in bits [3:0]
//   bin_out    out  BIN_W     binary result, held until the next completed conversion
//   busy       out  1         high from the cycle after an accepted start through DONE
//   done       out  1         one-cycle completion pulse, bin_out/err valid with it
//   err        out  1         invalid-digit flag, valid with done
//
// Optional feature macro: BCD_CHECK_EN
//   Defined   : any digit > 9 at start gives err=1 and bin_out=0 at done.
//   Undefined : err is tied 0 and invalid digits go through the normal algorithm.

module bcd_to_binary_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk_50MHz,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [BIN_W-1:0]   bin_out_q, bin_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Shift step: datapath for one resolved bit.
  logic [BCD_W-1:0]   bcd_shr;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BIN_W-1:0]   bin_shr;

`ifdef BCD_CHECK_EN
  logic               err_q, err_d;
  logic               bad_q, bad_d;
  logic               bad_in;

  // An operand digit above 9 is recorded when start is accepted and reported at done.
  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) begin
        bad_in = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    bcd_shr = bcd_q >> 1;
    bin_shr = {bcd_q[0], bin_q[BIN_W-1:1]};
    bcd_adj = bcd_shr;
    // A shifted digit is >= 8 exactly when its top bit is set. Subtracting 3
    // corrects the 16/2 = 8 that the next digit's LSB brought in to 10/2 = 5.
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_shr[4*i + 3]) begin
        bcd_adj[4*i +: 4] = bcd_shr[4*i +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    count_d   = count_q;
    bin_out_d = bin_out_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
`ifdef BCD_CHECK_EN
    err_d     = 1'b0;
    bad_d     = bad_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          bcd_d   = bcd_in;
          bin_d   = '0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
`ifdef BCD_CHECK_EN
          bad_d   = bad_in;
`endif
        end
      end

      S_SHIFT: begin
        bcd_d   = bcd_adj;
        bin_d   = bin_shr;
        count_d = count_q + CNT_W'(1);
        busy_d  = 1'b1;
        if (count_q == LAST_SHIFT) begin
          // Capture the final shifted value on entry to DONE. This makes
          // bin_out valid in the same cycle as the done pulse.
          state_d   = S_DONE;
          done_d    = 1'b1;
`ifdef BCD_CHECK_EN
          bin_out_d = bad_q ? '0 : bin_shr;
          err_d     = bad_q;
`else
          bin_out_d = bin_shr;
`endif
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      count_q   <= '0;
      bin_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef BCD_CHECK_EN
      err_q     <= 1'b0;
      bad_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      count_q   <= count_d;
      bin_out_q <= bin_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef BCD_CHECK_EN
      err_q     <= err_d;
      bad_q     <= bad_d;
`endif
    end
  end

  assign bin_out = bin_out_q;
  assign busy    = busy_q;
  assign done    = done_q;
`ifdef BCD_CHECK_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule
